// File: rtl/dmem_bus_if_pkg.sv
// Shared constants for the data-memory bus interface: access-size
// encodings, FSM state encoding and default parameter values.
package dmem_bus_if_pkg;

    // Access size encoding, shared by req_size and the SIZE bus output
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Default bounded-wait settings
    localparam int TIMEOUT_DEFAULT = 255;
    localparam int CNT_W_DEFAULT   = 16;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane handling: write-lane replication and the
// legality check on the incoming request, and read-lane extraction with
// sign/zero extension on the captured bus data.
module dmem_lane_align (
    input  logic [1:0]  wr_size,
    input  logic [1:0]  wr_addr_lo,
    input  logic [31:0] wr_data,
    output logic [31:0] wr_lanes,
    output logic        illegal,
    input  logic [1:0]  rd_size,
    input  logic [1:0]  rd_addr_lo,
    input  logic        rd_sign,
    input  logic [31:0] rd_bus,
    output logic [31:0] rd_data
);
    import dmem_bus_if_pkg::*;

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Replicate narrow store data across every lane it could land on
    always_comb begin
        wr_lanes = wr_data;
        case (wr_size)
            SZ_BYTE: wr_lanes = {4{wr_data[7:0]}};
            SZ_HALF: wr_lanes = {2{wr_data[15:0]}};
            SZ_WORD: wr_lanes = wr_data;
            default: wr_lanes = wr_data;
        endcase
    end

    // Flag an illegal size or an address not aligned to the access size
    always_comb begin
        illegal = 1'b1;
        case (wr_size)
            SZ_BYTE: illegal = 1'b0;
            SZ_HALF: illegal = wr_addr_lo[0];
            SZ_WORD: illegal = (wr_addr_lo != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    // Pick the addressed lane out of the bus word and extend it to 32 bits
    always_comb begin
        byte_s  = rd_bus[{rd_addr_lo, 3'b000} +: 8];
        half_s  = rd_bus[{rd_addr_lo[1], 4'b0000} +: 16];
        rd_data = rd_bus;
        case (rd_size)
            SZ_BYTE: rd_data = {{24{rd_sign & byte_s[7]}}, byte_s};
            SZ_HALF: rd_data = {{16{rd_sign & half_s[15]}}, half_s};
            SZ_WORD: rd_data = rd_bus;
            default: rd_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_bus_if.sv
// Data-memory bus interface: takes one load/store from the MEM stage,
// runs the MREQ/ACKD_n handshake with a bounded wait, aligns lanes and
// returns a one-cycle response while stalling the pipeline meanwhile.
module dmem_bus_if #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] DAD,
    output logic [31:0] DDT_out,
    output logic        DDT_oe,
    input  logic [31:0] DDT_in,
    output logic        MREQ,
    output logic        WRITE,
    output logic [1:0]  SIZE,
    input  logic        ACKD_n
);
    import dmem_bus_if_pkg::*;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             write_r;
    logic             sign_r;

    logic             accept_s;
    logic             illegal_s;
    logic             ack_s;
    logic             timeout_s;
    logic [31:0]      wr_lanes_s;
    logic [31:0]      rd_ext_s;

    dmem_lane_align u_align (
        .wr_size    (req_size),
        .wr_addr_lo (req_addr[1:0]),
        .wr_data    (req_wdata),
        .wr_lanes   (wr_lanes_s),
        .illegal    (illegal_s),
        .rd_size    (SIZE),
        .rd_addr_lo (DAD[1:0]),
        .rd_sign    (sign_r),
        .rd_bus     (DDT_in),
        .rd_data    (rd_ext_s)
    );

    assign req_ready = (state_r == ST_IDLE);
    assign accept_s  = req_valid & req_ready;
    assign ack_s     = ~ACKD_n;
    // Counter holds the number of BUS cycles already completed
    assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
    // Stall covers the accept cycle and every BUS cycle, released in RESP
    assign stall     = accept_s | (state_r == ST_BUS);

    // State register with asynchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state selection: accept, wait for ack or timeout, one response cycle
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (illegal_s) begin
                        state_s = ST_RESP;
                    end else begin
                        state_s = ST_BUS;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (ack_s || timeout_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_BUS;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Bus outputs, wait counter, request latches and response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            MREQ      <= 1'b0;
            WRITE     <= 1'b0;
            DDT_oe    <= 1'b0;
            DAD       <= 32'h0000_0000;
            SIZE      <= 2'b00;
            DDT_out   <= 32'h0000_0000;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            rsp_err   <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            write_r   <= 1'b0;
            sign_r    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (illegal_s) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0000_0000;
                        end else begin
                            MREQ    <= 1'b1;
                            WRITE   <= req_write;
                            DDT_oe  <= req_write;
                            DAD     <= req_addr;
                            SIZE    <= req_size;
                            DDT_out <= req_write ? wr_lanes_s : 32'h0000_0000;
                            write_r <= req_write;
                            sign_r  <= req_sign;
                            cnt_r   <= {CNT_W{1'b0}};
                        end
                    end
                end
                ST_BUS: begin
                    if (ack_s) begin
                        MREQ      <= 1'b0;
                        WRITE     <= 1'b0;
                        DDT_oe    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= write_r ? 32'h0000_0000 : rd_ext_s;
                    end else if (timeout_s) begin
                        MREQ      <= 1'b0;
                        WRITE     <= 1'b0;
                        DDT_oe    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'h0000_0000;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: begin
                    rsp_valid <= 1'b0;
                end
                default: begin
                    MREQ   <= 1'b0;
                    WRITE  <= 1'b0;
                    DDT_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_if.sv
// Self-checking bench for dmem_bus_if: directed vector table, randomized
// transactions against a reference model, and an async-reset sequence.
module tb_dmem_bus_if;

    localparam int TOUT = 4;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] DAD;
    logic [31:0] DDT_out;
    logic        DDT_oe;
    logic [31:0] DDT_in;
    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;
    logic        ACKD_n;

    int checks;
    int errors;

    dmem_bus_if #(.TIMEOUT_CYCLES(TOUT), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_sign  (req_sign),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .stall     (stall),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .DAD       (DAD),
        .DDT_out   (DDT_out),
        .DDT_oe    (DDT_oe),
        .DDT_in    (DDT_in),
        .MREQ      (MREQ),
        .WRITE     (WRITE),
        .SIZE      (SIZE),
        .ACKD_n    (ACKD_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
        logic [31:0] rbus;
        int          wait_n;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_lanes;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: legality of a request
    function automatic logic m_illegal(input logic [1:0] size, input logic [31:0] addr);
        int lo;
        lo = int'(addr % 32'd4);
        if (size == 2'd3) return 1'b1;
        if (size == 2'd1) return (lo % 2) != 0;
        if (size == 2'd2) return lo != 0;
        return 1'b0;
    endfunction

    // Reference model: store data as it appears on the 32-bit bus
    function automatic logic [31:0] m_lanes(input logic [1:0] size, input logic [31:0] wdata);
        if (size == 2'd0) return (wdata & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (wdata & 32'hFFFF) * 32'h0001_0001;
        return wdata;
    endfunction

    // Reference model: loaded value after lane selection and extension
    function automatic logic [31:0] m_read(input logic [1:0] size, input logic [31:0] addr,
                                           input logic sgn, input logic [31:0] rbus);
        logic [31:0] v;
        int lo;
        lo = int'(addr % 32'd4);
        if (size == 2'd0) begin
            v = (rbus >> (8 * lo)) & 32'hFF;
            if (sgn && v >= 32'd128) v = v - 32'd256;
        end else if (size == 2'd1) begin
            v = (rbus >> (16 * (lo / 2))) & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = rbus;
        end
        return v;
    endfunction

    // Runs one transaction starting just after a rising edge; checks every cycle
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] wdata, input logic [31:0] rbus,
                           input int wait_n, input logic [31:0] exp_rdata,
                           input logic exp_err, input logic [31:0] exp_lanes);
        int nb;
        int ackc;
        logic [5:0] exp_ctrl;
        logic [5:0] got_ctrl;
        logic mreq_e;
        ackc = wait_n + 1;
        if (m_illegal(size, addr)) nb = 0;
        else if (ackc <= TOUT) nb = ackc;
        else nb = TOUT;
        for (int c = 0; c <= nb + 2; c++) begin
            if (c == 0) begin
                req_valid = 1'b1;
                req_write = wr;
                req_addr  = addr;
                req_size  = size;
                req_sign  = sgn;
                req_wdata = wdata;
            end else begin
                req_valid = 1'b0;
                req_write = 1'($urandom_range(0, 1));
                req_addr  = $urandom();
                req_size  = 2'($urandom_range(0, 3));
                req_sign  = 1'($urandom_range(0, 1));
                req_wdata = $urandom();
            end
            DDT_in = (c == ackc) ? rbus : $urandom();
            if (c == ackc) ACKD_n = 1'b0;
            else if (c > nb) ACKD_n = 1'($urandom_range(0, 1));
            else ACKD_n = 1'b1;
            @(negedge clk);
            mreq_e   = (c >= 1) && (c <= nb);
            exp_ctrl = {(c == 0) || (c > nb + 1), c <= nb, c == nb + 1,
                        mreq_e, mreq_e & wr, mreq_e & wr};
            got_ctrl = {req_ready, stall, rsp_valid, MREQ, WRITE, DDT_oe};
            chk("ctrl{rdy,stall,rspv,mreq,write,oe}", 32'(got_ctrl), 32'(exp_ctrl));
            if (mreq_e) begin
                chk("DAD", DAD, addr);
                chk("SIZE", 32'(SIZE), 32'(size));
                if (wr) chk("DDT_out", DDT_out, exp_lanes);
            end
            if (c >= nb + 1) begin
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_err", 32'(rsp_err), 32'(exp_err));
            end
            @(posedge clk);
            #1;
        end
        ACKD_n    = 1'b1;
        req_valid = 1'b0;
    endtask

    initial begin
        logic        r_wr;
        logic        r_sgn;
        logic [31:0] r_addr;
        logic [31:0] r_wdata;
        logic [31:0] r_rbus;
        logic [1:0]  r_size;
        int          r_wait;
        logic        r_bad;
        logic        r_tout;

        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_size  = 2'b00;
        req_sign  = 1'b0;
        req_wdata = 32'h0;
        DDT_in    = 32'h0;
        ACKD_n    = 1'b1;

        // Reset state
        @(negedge clk);
        chk("reset ctrl{rdy,stall,rspv,mreq,write,oe}",
            32'({req_ready, stall, rsp_valid, MREQ, WRITE, DDT_oe}), 32'h20);
        chk("reset DAD", DAD, 32'h0);
        chk("reset DDT_out", DDT_out, 32'h0);
        chk("reset SIZE", 32'(SIZE), 32'h0);
        chk("reset rsp_rdata", rsp_rdata, 32'h0);
        chk("reset rsp_err", 32'(rsp_err), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors: wr, addr, size, sign, wdata, rbus, wait, rdata, err, lanes
        vecs[0]  = '{1'b0, 32'h100, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 0,  32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h103, 2'd0, 1'b1, 32'h0,        32'h80FFFF7F, 3,  32'hFFFFFF80, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 32'h202, 2'd1, 1'b0, 32'h0000ABCD, 32'h0,        0,  32'h0,        1'b0, 32'hABCDABCD};
        vecs[3]  = '{1'b0, 32'h102, 2'd2, 1'b0, 32'h0,        32'h12345678, 0,  32'h0,        1'b1, 32'h0};
        vecs[4]  = '{1'b0, 32'h300, 2'd2, 1'b0, 32'h0,        32'h55555555, 10, 32'h0,        1'b1, 32'h0};
        vecs[5]  = '{1'b0, 32'h102, 2'd1, 1'b0, 32'h0,        32'h87654321, 1,  32'h00008765, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 32'h100, 2'd1, 1'b1, 32'h0,        32'h1234F00D, 0,  32'hFFFFF00D, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 32'h005, 2'd0, 1'b0, 32'h123456A5, 32'h0,        2,  32'h0,        1'b0, 32'hA5A5A5A5};
        vecs[8]  = '{1'b0, 32'h000, 2'd3, 1'b0, 32'h0,        32'hFFFFFFFF, 0,  32'h0,        1'b1, 32'h0};
        vecs[9]  = '{1'b1, 32'h201, 2'd1, 1'b0, 32'h1111,     32'h0,        0,  32'h0,        1'b1, 32'h0};
        vecs[10] = '{1'b0, 32'h101, 2'd0, 1'b0, 32'h0,        32'h00009A00, 1,  32'h0000009A, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 32'h040, 2'd2, 1'b0, 32'hCAFEBABE, 32'h0,        4,  32'h0,        1'b1, 32'hCAFEBABE};

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].sgn, vecs[i].wdata,
                    vecs[i].rbus, vecs[i].wait_n, vecs[i].exp_rdata, vecs[i].exp_err,
                    vecs[i].exp_lanes);
        end

        // Asynchronous reset during a BUS wait, with a late ack afterwards
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h400;
        req_size  = 2'd2;
        req_sign  = 1'b0;
        req_wdata = 32'h11223344;
        ACKD_n    = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("pre-reset {mreq,write,oe}", 32'({MREQ, WRITE, DDT_oe}), 32'h7);
        rst = 1'b0;
        #1;
        chk("async reset {mreq,write,oe,rspv,stall}",
            32'({MREQ, WRITE, DDT_oe, rsp_valid, stall}), 32'h0);
        ACKD_n = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("late ack ignored {rdy,rspv,mreq}", 32'({req_ready, rsp_valid, MREQ}), 32'h4);
            @(posedge clk);
            #1;
        end
        ACKD_n = 1'b1;
        run_txn(1'b0, 32'h500, 2'd2, 1'b0, 32'h0, 32'hA5A55A5A, 1, 32'hA5A55A5A, 1'b0, 32'h0);

        // Randomized transactions against the reference model
        for (int n = 0; n < 60; n++) begin
            r_wr    = 1'($urandom_range(0, 1));
            r_sgn   = 1'($urandom_range(0, 1));
            r_addr  = $urandom();
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) r_addr = r_addr | 32'h2;
            r_size  = 2'($urandom_range(0, 3));
            r_wdata = $urandom();
            r_rbus  = $urandom();
            r_wait  = $urandom_range(0, 6);
            r_bad   = m_illegal(r_size, r_addr);
            r_tout  = !r_bad && (r_wait + 1 > TOUT);
            run_txn(r_wr, r_addr, r_size, r_sgn, r_wdata, r_rbus, r_wait,
                    (r_bad || r_tout || r_wr) ? 32'h0 : m_read(r_size, r_addr, r_sgn, r_rbus),
                    r_bad || r_tout, m_lanes(r_size, r_wdata));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_bus_if.md
Name: dmem_bus_if

Overview:
Data-memory bus interface unit between the core's MEM stage and the external data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
- Accepts one load/store request at a time and runs the ACKD_n handshake with a bounded-wait timeout.
- Performs byte-lane alignment and sign/zero extension.
- Raises a stall to the pipeline while a transfer is in flight.

Parameters:
TIMEOUT_CYCLES, 255, max bus cycles waiting for ACKD_n before aborting with error (1..65535)
CNT_W, 16, width of wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  MEM stage presents a load/store
req_write  in  1  1=store, 0=load
req_addr  in  32  byte address
req_size  in  2  00=byte, 01=half, 10=word; 11 is illegal
req_sign  in  1  sign-extend loaded data
req_wdata  in  32  store data, right-justified
req_ready  out  1  request accepted this cycle
stall  out  1  freeze IF..MEM pipeline registers
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned, illegal size, or timeout; valid with rsp_valid
DAD  out  32  data address bus
DDT_out  out  32  lane-aligned write data
DDT_oe  out  1  write-data tri-state enable (top drives DDT)
DDT_in  in  32  read data from bus
MREQ  out  1  memory request, active high
WRITE  out  1  write strobe, active high
SIZE  out  2  access size, same encoding as req_size
ACKD_n  in  1  data acknowledge, active low

Behaviour:
- FSM states: IDLE, BUS, RESP. State, counter and all registered outputs are asynchronously cleared when rst=0.
- Reset values: MREQ=0, WRITE=0, DDT_oe=0, DAD=0, SIZE=0, DDT_out=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, stall=0.
- req_ready=1 only in IDLE (combinational). Accept = req_valid & req_ready.
- Accept, legal request: latch addr/size/sign/write/wdata.
  - Next cycle enter BUS with MREQ=1, DAD=addr, SIZE=size, WRITE=req_write, DDT_oe=req_write.
- Accept, illegal request: no bus cycle; go directly to RESP with rsp_err=1.
  - Illegal = size 11, half with addr[0]=1, or word with addr[1:0]!=00.
- BUS:
  - Bus outputs hold stable every cycle. Counter increments each cycle.
  - ACKD_n sampled low: capture DDT_in (loads), go to RESP, drop MREQ/WRITE/DDT_oe.
  - Counter reaches TIMEOUT_CYCLES without ack: go to RESP with rsp_err=1, drop bus signals.
  - An ack in the same cycle as timeout wins (no error).
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata and rsp_err hold until the next RESP.
- stall=1 from the accept cycle through the cycle before RESP; stall=0 in RESP so the pipeline advances with the result.
- Minimum latency (zero-wait ack): accept at cycle 0, MREQ at 1, rsp_valid at 2.
- Write lanes, little-endian:
  - Byte: wdata[7:0] replicated to all 4 lanes.
  - Half: wdata[15:0] replicated to both halves.
  - Word: passed through unchanged.
- Read extraction:
  - Byte: lane addr[1:0], i.e. DDT_in[8*addr[1:0]+:8].
  - Half: DDT_in[16*addr[1]+:16].
  - Extension: sign-extend if sign=1, else zero-extend.
- Reset mid-transfer: MREQ is removed asynchronously and no rsp_valid is issued; a late ACKD_n is ignored in IDLE.
- ACKD_n low while in IDLE or RESP: ignored.

Decomposition:
- Shared constants package: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and FSM state encodings, alongside the existing constants.
- One sub-module: dmem_lane_align, purely combinational. It holds the write-lane replication, read-lane extraction/extension and the misalignment check.

Test Plan:
- Word load, addr 0x100, ACKD_n low on first BUS cycle, DDT_in=0xDEADBEEF -> MREQ high one cycle, rsp_valid at cycle 2, rsp_rdata=0xDEADBEEF, rsp_err=0, stall high cycles 0-1.
- Signed byte load, addr 0x103, DDT_in=0x80FF_FF7F, 3 wait cycles -> rsp_rdata=0xFFFFFF80, stall held 5 cycles, DAD/SIZE stable throughout BUS.
- Half store, addr 0x202, wdata=0x0000ABCD -> DDT_out=0xABCDABCD, DDT_oe=1, WRITE=1, SIZE=01; rsp_rdata=0.
- Misaligned word load, addr 0x102 -> MREQ never asserts, rsp_valid one cycle after accept with rsp_err=1.
- TIMEOUT_CYCLES=4, ACKD_n held high -> MREQ drops after 4 BUS cycles, rsp_err=1; an ack arriving later is ignored.
- rst asserted low during a BUS wait -> MREQ/WRITE/DDT_oe drop immediately, no rsp_valid; the next request completes normally.
